// File: rtl/polaris_pkg.sv
// ============================================================================
// polaris_pkg
// Shared fetch/trap constants and the fetch state type.
// Revision: 1.0
// ============================================================================
`default_nettype none

package polaris_pkg;

    // Bus cycle size codes
    localparam logic [1:0] SIZE_IDLE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    // Trap cause codes (low bits of MCAUSE)
    localparam int MCAUSE_ILLEGAL = 2;
    localparam int MCAUSE_MEI     = 11;

    // Fetch sequencer states; FETCH_HI is only reached on a 16-bit bus
    typedef enum logic [1:0] {
        FETCH_LO = 2'd0,
        FETCH_HI = 2'd1,
        DECODE   = 2'd2
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_trap_sel.sv
// ============================================================================
// fetch_trap_sel
// Combinational trap priority selector: pause beats illegal-opcode beats
// interrupt. Produces the trap strobe plus MEPC/MCAUSE values.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_trap_sel
    import polaris_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic              decode_i,
    input  logic              pause_i,
    input  logic              defined_i,
    input  logic              irq_en_i,
    input  logic [XLEN-3:0]   cpc_i,
    input  logic [XLEN-3:0]   npc_i,
    output logic              trap_o,
    output logic [XLEN-1:0]   mepc_o,
    output logic [XLEN-1:0]   mcause_o
);

    // Priority select; outputs stay zero unless a trap is actually taken
    always_comb begin
        trap_o   = 1'b0;
        mepc_o   = '0;
        mcause_o = '0;
        if (decode_i && !pause_i) begin
            if (!defined_i) begin
                // Illegal opcode: return address is the faulting instruction
                trap_o   = 1'b1;
                mepc_o   = {cpc_i, 2'b00};
                mcause_o = XLEN'(MCAUSE_ILLEGAL);
            end else if (irq_en_i) begin
                // Interrupt: the current instruction completes, resume at npc
                trap_o   = 1'b1;
                mepc_o   = {npc_i, 2'b00};
                mcause_o = {1'b1, {(XLEN-5){1'b0}}, 4'(MCAUSE_MEI)};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_wide.sv
// ============================================================================
// fetch_wide
// Instruction fetcher: one 32-bit opcode per instruction over a 16- or
// 32-bit read-only bus, with illegal-opcode and external-interrupt traps
// that redirect the next fetch to MTVEC.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_wide
    import polaris_pkg::*;
#(
    parameter int          XLEN     = 64,
    parameter int          DAT_W    = 16,
    parameter logic [63:0] RESET_PC = 64'hFFFF_FFFF_FFFF_FF00
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DAT_W-1:0]  dat_i,
    input  logic              ack_i,
    output logic [XLEN-1:0]   adr_o,
    output logic [1:0]        size_o,
    output logic              we_o,
    output logic              vpa_o,
    output logic [31:0]       ir_o,
    output logic              ir_valid_o,
    output logic [XLEN-1:0]   cpc_o,
    input  logic              defined_i,
    input  logic              pause_i,
    input  logic              irq_i,
    input  logic              mie_i,
    input  logic [XLEN-3:0]   csr_mtvec_i,
    output logic [XLEN-1:0]   mepc_o,
    output logic [XLEN-1:0]   mcause_o,
    output logic              trap_o
);

    localparam int             AW        = XLEN - 2;
    localparam logic [AW-1:0]  RESET_NPC = RESET_PC[XLEN-1:2];
    localparam logic [1:0]     LO_SIZE   = (DAT_W == 16) ? SIZE_HALF : SIZE_WORD;

    // Reject unsupported widths at elaboration time
    generate
        if (!(DAT_W == 16 || DAT_W == 32)) begin : g_bad_dat_w
            $error("fetch_wide: DAT_W must be 16 or 32");
        end
        if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
            $error("fetch_wide: XLEN must be 32 or 64");
        end
    endgenerate

    fetch_state_e   state_q, state_d;
    logic [AW-1:0]  npc_q, npc_d;      // word address of next fetch
    logic [AW-1:0]  cpc_q, cpc_d;      // word address of instruction in ir
    logic [31:0]    ir_q, ir_d;
    logic [15:0]    irl_q, irl_d;      // low halfword held between fetch cycles

    logic [31:0]    dat32;
    logic           decode;

    // Zero-extends a 16-bit bus; exact on a 32-bit bus
    assign dat32  = 32'(dat_i);
    assign decode = (state_q == DECODE);
    assign we_o   = 1'b0;
    assign ir_o   = ir_q;
    assign cpc_o  = {cpc_q, 2'b00};

    fetch_trap_sel #(
        .XLEN (XLEN)
    ) u_trap_sel (
        .decode_i  (decode),
        .pause_i   (pause_i),
        .defined_i (defined_i),
        .irq_en_i  (irq_i & mie_i),
        .cpc_i     (cpc_q),
        .npc_i     (npc_q),
        .trap_o    (trap_o),
        .mepc_o    (mepc_o),
        .mcause_o  (mcause_o)
    );

    // State and fetch registers; reset abandons any bus cycle in flight
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= FETCH_LO;
            npc_q   <= RESET_NPC;
            cpc_q   <= '0;
            ir_q    <= '0;
            irl_q   <= '0;
        end else begin
            state_q <= state_d;
            npc_q   <= npc_d;
            cpc_q   <= cpc_d;
            ir_q    <= ir_d;
            irl_q   <= irl_d;
        end
    end

    // Next-state: advance on ack in fetch states, leave DECODE unless paused
    always_comb begin
        state_d = state_q;
        npc_d   = npc_q;
        cpc_d   = cpc_q;
        ir_d    = ir_q;
        irl_d   = irl_q;
        unique case (state_q)
            FETCH_LO: begin
                if (ack_i) begin
                    if (DAT_W == 16) begin
                        irl_d   = dat_i[15:0];
                        state_d = FETCH_HI;
                    end else begin
                        ir_d    = dat32;
                        cpc_d   = npc_q;
                        npc_d   = npc_q + AW'(1);
                        state_d = DECODE;
                    end
                end
            end
            FETCH_HI: begin
                if (ack_i) begin
                    ir_d    = {dat_i[15:0], irl_q};
                    cpc_d   = npc_q;
                    npc_d   = npc_q + AW'(1);
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (!pause_i) begin
                    state_d = FETCH_LO;
                    if (trap_o) begin
                        npc_d = csr_mtvec_i;
                    end
                end
            end
            default: state_d = FETCH_LO;
        endcase
    end

    // Bus outputs follow state; held idle while reset is asserted
    always_comb begin
        adr_o      = '0;
        size_o     = SIZE_IDLE;
        vpa_o      = 1'b0;
        ir_valid_o = 1'b0;
        if (!reset_i) begin
            unique case (state_q)
                FETCH_LO: begin
                    adr_o  = {npc_q, 2'b00};
                    size_o = LO_SIZE;
                    vpa_o  = 1'b1;
                end
                FETCH_HI: begin
                    adr_o  = {npc_q, 2'b10};
                    size_o = SIZE_HALF;
                    vpa_o  = 1'b1;
                end
                DECODE: begin
                    ir_valid_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
